// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST session controller.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } bist_state_t;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int LAT_MAX   = 15;
  localparam int FLUSH_W   = 4;

  function automatic logic is_busy(input bist_state_t s);
    logic b;
    case (s)
      INIT, RUN, FLUSH, COMPARE: b = 1'b1;
      default:                   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bist_down_counter.sv
// Loadable down counter with zero/one flags; saturates at zero instead of wrapping.
module bist_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});
  assign one_o  = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/bist_controller.sv
// BIST session sequencer: INIT -> RUN -> FLUSH -> COMPARE -> DONE with registered outputs.
// Optional BIST_SIG_CAPTURE_EN adds the captured_sig output.
module bist_controller
  import bist_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N-1:0]     golden_sig,
  input  logic [N-1:0]     signature,
  output logic             init,
  output logic             tpg_en,
  output logic             misr_en,
  output logic             test_mode,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef BIST_SIG_CAPTURE_EN
  ,
  output logic [N-1:0]     captured_sig
`endif
);

  localparam logic [FLUSH_W-1:0] LAT_V = LAT[FLUSH_W-1:0];

  bist_state_t state_q, state_d;
  logic pat_zero, pat_one, fl_zero, fl_one;
  logic abort_take, start_take;
  logic init_q, tpg_q, misr_q, tm_q, busy_q, done_q, pass_q, pass_r_q;
  logic init_d, tpg_d, misr_d, tm_d, busy_d, done_d, pass_d, pass_r_d;

  // Abort+start in DONE returns to IDLE; abort alone there is ignored.
  assign abort_take = abort && (is_busy(state_q) || ((state_q == DONE) && start));
  assign start_take = start && !abort_take && ((state_q == IDLE) || (state_q == DONE));

  bist_down_counter #(.W(CNT_W)) u_pat_cnt (
    .clk(clk), .rst(rst),
    .load_i(start_take), .load_val_i(num_patterns),
    .dec_i(state_q == RUN),
    .zero_o(pat_zero), .one_o(pat_one)
  );

  bist_down_counter #(.W(FLUSH_W)) u_flush_cnt (
    .clk(clk), .rst(rst),
    .load_i(state_q != FLUSH), .load_val_i(LAT_V),
    .dec_i(state_q == FLUSH),
    .zero_o(fl_zero), .one_o(fl_one)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? INIT : IDLE;
      INIT: begin
        if (!pat_zero)     state_d = RUN;
        else if (LAT != 0) state_d = FLUSH;
        else               state_d = COMPARE;
      end
      RUN: begin
        if (!pat_one)      state_d = RUN;
        else if (LAT != 0) state_d = FLUSH;
        else               state_d = COMPARE;
      end
      FLUSH:   state_d = (fl_one || fl_zero) ? COMPARE : FLUSH;
      COMPARE: state_d = DONE;
      DONE:    state_d = start ? INIT : DONE;
      default: state_d = IDLE;
    endcase
    if (abort_take) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the upcoming state; done/pass trail DONE entry by one cycle.
  always_comb begin
    init_d   = (state_d == INIT);
    tpg_d    = (state_d == RUN);
    misr_d   = (state_d == RUN) || (state_d == FLUSH);
    tm_d     = is_busy(state_d);
    busy_d   = is_busy(state_d);
    done_d   = (state_q == DONE) && (state_d == DONE);
    pass_d   = done_d && pass_r_q;
    pass_r_d = pass_r_q;
    if (abort_take) begin
      pass_r_d = 1'b0;
    end else if (state_q == COMPARE) begin
      pass_r_d = (signature == golden_sig);
    end else begin
      pass_r_d = pass_r_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      tpg_q    <= 1'b0;
      misr_q   <= 1'b0;
      tm_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      pass_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      tpg_q    <= tpg_d;
      misr_q   <= misr_d;
      tm_q     <= tm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      pass_r_q <= pass_r_d;
    end
  end

  assign init      = init_q;
  assign tpg_en    = tpg_q;
  assign misr_en   = misr_q;
  assign test_mode = tm_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef BIST_SIG_CAPTURE_EN
  logic [N-1:0] cap_q, cap_d;

  // Signature snapshot taken in COMPARE, held until abort or the next COMPARE.
  always_comb begin
    if (abort_take) begin
      cap_d = {N{1'b0}};
    end else if (state_q == COMPARE) begin
      cap_d = signature;
    end else begin
      cap_d = cap_q;
    end
  end

  // Capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= {N{1'b0}};
    end else begin
      cap_q <= cap_d;
    end
  end

  assign captured_sig = cap_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: two instances (LAT=2/CNT_W=16 and LAT=0/CNT_W=4).
module tb_bist_controller;

  localparam int N = 8;
  localparam logic [7:0] TPG_SEED  = 8'h01;
  localparam logic [7:0] MISR_SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic start_s [2];
  logic abort_s [2];
  logic [15:0] num0;
  logic [3:0]  num1;
  logic [N-1:0] golden_s [2];
  logic [N-1:0] sig_s [2];
  logic [N-1:0] misr_m [2];
  logic [N-1:0] tpg_m [2];
  logic [N-1:0] sig_mask [2];
  logic init_w [2], tpg_w [2], misr_w [2], tm_w [2], busy_w [2], done_w [2], pass_w [2];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

`ifdef BIST_SIG_CAPTURE_EN
  logic [N-1:0] cap_w [2];
`endif

  bist_controller #(.N(N), .CNT_W(16), .LAT(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
    .num_patterns(num0), .golden_sig(golden_s[0]), .signature(sig_s[0]),
    .init(init_w[0]), .tpg_en(tpg_w[0]), .misr_en(misr_w[0]), .test_mode(tm_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0])
`ifdef BIST_SIG_CAPTURE_EN
    , .captured_sig(cap_w[0])
`endif
  );

  bist_controller #(.N(N), .CNT_W(4), .LAT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
    .num_patterns(num1), .golden_sig(golden_s[1]), .signature(sig_s[1]),
    .init(init_w[1]), .tpg_en(tpg_w[1]), .misr_en(misr_w[1]), .test_mode(tm_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1])
`ifdef BIST_SIG_CAPTURE_EN
    , .captured_sig(cap_w[1])
`endif
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    return lfsr_step(s) ^ d;
  endfunction

  // Reference signature: num patterns compacted, then lat flush compactions with the TPG frozen.
  function automatic logic [7:0] ref_sig(input int num, input int lat);
    logic [7:0] t, m;
    t = TPG_SEED;
    m = MISR_SEED;
    for (int i = 0; i < num + lat; i++) begin
      m = misr_step(m, t);
      if (i < num) t = lfsr_step(t);
    end
    return m;
  endfunction

  // Environment TPG/MISR driven by the controller's enables.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        tpg_m[d]  <= 8'h00;
        misr_m[d] <= 8'h00;
      end else if (init_w[d]) begin
        tpg_m[d]  <= TPG_SEED;
        misr_m[d] <= MISR_SEED;
      end else begin
        if (misr_w[d]) misr_m[d] <= misr_step(misr_m[d], tpg_m[d]);
        if (tpg_w[d])  tpg_m[d]  <= lfsr_step(tpg_m[d]);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) sig_s[d] = misr_m[d] ^ sig_mask[d];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input int d, input string name);
    check(name, {25'd0, init_w[d], tpg_w[d], misr_w[d], tm_w[d], busy_w[d], done_w[d], pass_w[d]}, 32'd0);
  endtask

  // One session; abort_at/rst_at/start_at are cycle indices after the start edge (-1 = unused).
  task automatic session(input int d, input int num, input logic [7:0] flip,
                         input int abort_at, input int rst_at, input int start_at);
    int lat, n_init, n_tpg, n_misr, done_at;
    logic [7:0] g;
    lat = (d == 0) ? 2 : 0;
    n_init = 0; n_tpg = 0; n_misr = 0; done_at = -1;
    g = ref_sig(num, lat) ^ flip;
    @(negedge clk);
    if (d == 0) num0 = 16'(num); else num1 = 4'(num);
    golden_s[d] = g;
    start_s[d] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      n_init += int'(init_w[d]);
      n_tpg  += int'(tpg_w[d]);
      n_misr += int'(misr_w[d]);
      if (done_w[d] && done_at < 0) done_at = k;
      if (abort_at >= 0 && k == abort_at + 1) begin
        check("abort_drops_enables", {29'd0, tpg_w[d], misr_w[d], busy_w[d]}, 32'd0);
      end
      if (abort_at >= 0 && k == abort_at + 20) break;
      if (abort_at < 0 && done_at >= 0) break;
      if (k == abort_at) abort_s[d] = 1'b1;
      if (k == start_at) start_s[d] = 1'b1;
      if (k == rst_at) begin
        check("flush_state_before_rst", {29'd0, tpg_w[d], misr_w[d], tm_w[d]}, 32'd3);
        check("tpg_cycles_before_rst", n_tpg, num);
        rst = 1'b1;
        #1;
        check_all_zero(d, "async_rst_outputs");
        #1;
        rst = 1'b0;
        return;
      end
    end
    if (abort_at >= 0) begin
      check("abort_no_done", done_at, -1);
      check("abort_tpg_cycles", n_tpg, abort_at);
    end else begin
      check("init_pulses", n_init, 1);
      check("tpg_cycles", n_tpg, num);
      check("misr_cycles", n_misr, num + lat);
      check("done_latency", done_at, 1 + num + lat + 2);
      check("pass", pass_w[d], (flip == 8'h00) ? 1 : 0);
      @(negedge clk);
      check("done_hold", {30'd0, done_w[d], tm_w[d]}, 32'd2);
`ifdef BIST_SIG_CAPTURE_EN
      check("captured_sig", cap_w[d], ref_sig(num, lat));
      sig_mask[d] = 8'hFF;
      @(negedge clk);
      check("captured_sig_hold", cap_w[d], ref_sig(num, lat));
      sig_mask[d] = 8'h00;
`endif
    end
  endtask

  typedef struct {
    int d;
    int num;
    logic [7:0] flip;
    int abort_at;
    int rst_at;
    int start_at;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl = '{
      '{0, 10, 8'h00, -1, -1, -1},
      '{0, 10, 8'h08, -1, -1, -1},
      '{1,  0, 8'h00, -1, -1, -1},
      '{0, 10, 8'h00,  4, -1, -1},
      '{0, 10, 8'h00, -1, -1, -1},
      '{0, 10, 8'h00, -1, 11,  3},
      '{0,  7, 8'h00, -1, -1,  3},
      '{1, 15, 8'h00, -1, -1, -1},
      '{1, 15, 8'h80, -1, -1, -1}
    };
    rst = 1'b1;
    num0 = 16'd0;
    num1 = 4'd0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      golden_s[d] = 8'h00;
      sig_mask[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    check_all_zero(0, "reset_outputs_dut0");
    check_all_zero(1, "reset_outputs_dut1");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      session(tbl[i].d, tbl[i].num, tbl[i].flip, tbl[i].abort_at, tbl[i].rst_at, tbl[i].start_at);
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] fl;
      fl = ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      session(0, int'($urandom_range(0, 20)), fl, -1, -1, -1);
    end

    // DONE corner cases: abort alone ignored, abort+start returns to IDLE.
    session(0, 3, 8'h00, -1, -1, -1);
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort_in_done_ignored", done_w[0], 1);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check_all_zero(0, "abort_start_in_done");
    repeat (3) @(negedge clk);
    check("idle_after_abort_start", {30'd0, init_w[0], busy_w[0]}, 32'd0);
    session(0, 5, 8'h00, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
